// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: opcodes, command record and statistics width shared by the counter command sequencer
package counter_seq_pkg;
    localparam int CMD_DATA_W = 8;
    localparam int STATS_W = 16;
    typedef enum logic [1:0] {NOP_HOLD = 2'b00, LOAD = 2'b01, UP = 2'b10, DOWN = 2'b11} cmd_op_e;
    typedef struct packed {
        cmd_op_e               op;
        logic [CMD_DATA_W-1:0] arg;
    } cmd_t;
endpackage

// File: rtl/cnt_cmd_fifo.sv
// cnt_cmd_fifo: synchronous command FIFO with wrap-bit pointers; an entry is poppable the cycle after its push
module cnt_cmd_fifo #(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W+1:0] wdata,
    input  logic              pop,
    output logic [DATA_W+1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wp_q, rp_q;
    assign empty = wp_q == rp_q;
    assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign rdata = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push && !full) begin
                mem_q[wp_q[AW-1:0]] <= wdata;
                wp_q <= wp_q + 1'b1;
            end
            if (pop && !empty) rp_q <= rp_q + 1'b1;
        end
    end
endmodule

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: turns queued load/up/down/hold commands into registered counter control pins
// Optional statistics ports done_count/drop_count exist only when CNT_SEQ_STATS_EN is defined.
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  cmd_op_e           cmd_op,
    input  logic [DATA_W-1:0] cmd_arg,
    output logic [DATA_W-1:0] data_in,
    output logic              load,
    output logic              enable,
    output logic              up_down,
    output logic              busy,
    output logic              cmd_done
`ifdef CNT_SEQ_STATS_EN
    ,
    output logic [STATS_W-1:0] done_count,
    output logic [STATS_W-1:0] drop_count
`endif
);
    typedef enum logic {IDLE, EXEC} state_e;
    state_e state_q;
    logic full, empty, pop, last, head_go;
    logic [DATA_W+1:0] head;
    cmd_op_e head_op;
    logic [DATA_W-1:0] head_arg, head_rem, rem_q, data_in_q;
    logic load_q, enable_q, up_down_q, busy_q, done_q;
    assign cmd_ready = !full && !reset;
    assign last = (state_q == EXEC) && (rem_q == '0);
    assign pop = ((state_q == IDLE) || last) && !empty;
    assign head_op = cmd_op_e'(head[DATA_W+1:DATA_W]);
    assign head_arg = head[DATA_W-1:0];
    assign head_go = ((head_op == UP) || (head_op == DOWN)) && (head_arg != '0);
    // rem counts the cycles still to run after the current one; zero-length ops become one hold cycle
    assign head_rem = ((head_op == LOAD) || (head_arg == '0)) ? '0 : head_arg - 1'b1;
    cnt_cmd_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_op, cmd_arg}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q <= '0;
            data_in_q <= '0;
            load_q <= 1'b0;
            enable_q <= 1'b0;
            up_down_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (pop) begin
            state_q <= EXEC;
            rem_q <= head_rem;
            load_q <= head_op == LOAD;
            enable_q <= head_go;
            if (head_go) up_down_q <= head_op == UP;
            if (head_op == LOAD) data_in_q <= head_arg;
            busy_q <= 1'b1;
            done_q <= head_rem == '0;
        end else if (last) begin
            state_q <= IDLE;
            load_q <= 1'b0;
            enable_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (state_q == EXEC) begin
            rem_q <= rem_q - 1'b1;
            done_q <= rem_q == DATA_W'(1);
        end
    end
    assign data_in = data_in_q;
    assign load = load_q;
    assign enable = enable_q;
    assign up_down = up_down_q;
    assign busy = busy_q;
    assign cmd_done = done_q;
`ifdef CNT_SEQ_STATS_EN
    logic [STATS_W-1:0] done_count_q, drop_count_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            done_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            if (done_q) done_count_q <= done_count_q + 1'b1;
            if (cmd_valid && !cmd_ready && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
        end
    end
    assign done_count = done_count_q;
    assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: directed and random command streams checked cycle by cycle against a schedule model
module tb_counter_cmd_sequencer;
    import counter_seq_pkg::*;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic          ld;
        logic          en;
        logic          ud;
        logic          dn;
        logic [DW-1:0] d;
    } rec_t;
    logic clk = 1'b0;
    logic reset = 1'b1, cmd_valid = 1'b0;
    cmd_op_e cmd_op = NOP_HOLD;
    logic [DW-1:0] cmd_arg = '0;
    logic cmd_ready, load, enable, up_down, busy, cmd_done;
    logic [DW-1:0] data_in;
`ifdef CNT_SEQ_STATS_EN
    logic [15:0] done_count, drop_count;
`endif
    int checks = 0, errors = 0;
    cmd_t fifo[$];
    rec_t sched[$];
    logic [DW-1:0] m_data = '0, cnt = '0, peak = '0;
    logic m_ud = 1'b0, acc = 1'b0;
    logic [15:0] m_done = '0;
    int m_drop = 0;

    always #5 clk = ~clk;

    counter_cmd_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .data_in   (data_in),
        .load      (load),
        .enable    (enable),
        .up_down   (up_down),
        .busy      (busy),
        .cmd_done  (cmd_done)
`ifdef CNT_SEQ_STATS_EN
        ,
        .done_count(done_count),
        .drop_count(drop_count)
`endif
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A command becomes a list of per-cycle control records; the last carries cmd_done.
    function automatic void expand(cmd_t c);
        int n;
        n = (c.op == LOAD || c.arg == 0) ? 1 : int'(c.arg);
        for (int i = 0; i < n; i++) begin
            rec_t r;
            r.ld = c.op == LOAD;
            r.en = (c.op == UP || c.op == DOWN) && c.arg != 0;
            r.ud = c.op == UP;
            r.dn = i == n - 1;
            r.d = c.arg;
            sched.push_back(r);
        end
    endfunction

    task automatic cyc(bit r, bit v, cmd_op_e op, logic [DW-1:0] arg);
        bit rdy, b;
        rec_t cur;
        reset = r;
        cmd_valid = v;
        cmd_op = op;
        cmd_arg = arg;
        #1;
        rdy = !r && fifo.size() < DEPTH;
        check("cmd_ready", 32'(cmd_ready), 32'(rdy));
        acc = v && rdy;
        @(posedge clk);
        if (r) begin
            fifo.delete();
            sched.delete();
            m_data = '0;
            m_ud = 1'b0;
            m_done = '0;
            m_drop = 0;
        end else begin
            if (sched.size() > 0) begin
                if (sched[0].dn) m_done++;
                sched.delete(0);
            end
            if (sched.size() == 0 && fifo.size() > 0) expand(fifo.pop_front());
            if (acc) fifo.push_back('{op: op, arg: arg});
            if (v && !rdy && m_drop < 65535) m_drop++;
        end
        #1;
        b = sched.size() > 0;
        cur = b ? sched[0] : '0;
        if (cur.ld) m_data = cur.d;
        if (cur.en) m_ud = cur.ud;
        check("outputs{ld,en,ud,busy,done,data}", 32'({load, enable, up_down, busy, cmd_done, data_in}),
              32'({cur.ld, cur.en, m_ud, b, cur.dn, m_data}));
`ifdef CNT_SEQ_STATS_EN
        check("done_count", 32'(done_count), 32'(m_done));
        check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
        cnt = load ? data_in : enable ? (up_down ? cnt + 1'b1 : cnt - 1'b1) : cnt;
        if (cnt > peak) peak = cnt;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, NOP_HOLD, '0);
    endtask

    task automatic send(cmd_op_e op, logic [DW-1:0] arg);
        int n = 0;
        do begin
            cyc(0, 1, op, arg);
            n++;
        end while (!acc && n < 100);
        check("send_accept", 32'(acc), 32'd1);
    endtask

    initial begin
        cyc(1, 0, NOP_HOLD, '0);
        cyc(1, 1, UP, 8'd3);
        idle(2);
        send(LOAD, 8'd123);
        idle(4);
        send(LOAD, 8'd10);
        send(UP, 8'd5);
        send(DOWN, 8'd2);
        send(NOP_HOLD, 8'd3);
        peak = '0;
        idle(15);
        check("counter_peak", 32'(peak), 32'd15);
        check("counter_final", 32'(cnt), 32'd13);
        send(UP, 8'd20);
        send(LOAD, 8'd1);
        send(UP, 8'd2);
        send(DOWN, 8'd1);
        send(NOP_HOLD, 8'd2);
        send(UP, 8'd3);
        idle(15);
        send(UP, 8'd0);
        send(LOAD, 8'd9);
        idle(4);
        send(UP, 8'd10);
        send(LOAD, 8'd7);
        send(DOWN, 8'd3);
        idle(1);
        cyc(1, 1, UP, 8'd5);
        idle(6);
        check("busy_after_abort", 32'(busy), 32'd0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), cmd_op_e'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 4)));
        for (int i = 0; i < 2000 && (busy || fifo.size() > 0); i++) cyc(0, 0, NOP_HOLD, '0);
        check("drained_busy", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
